// File: rtl/excl_window_checker.sv
// Multi-channel run-time checker: after a, b must stay low until the next a.
// Adds bounded windows, sticky flags, a saturating error count and first-error capture.
module excl_window_checker #(
  parameter int NCH = 4,
  parameter int MAX_GAP = 16,
  parameter int GAP_W = 8,
  parameter int CNT_W = 16,
  parameter int CLOSE_INCL = 1,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [NCH-1:0]   sig_a,
  input  logic [NCH-1:0]   sig_b,
  input  logic [NCH-1:0]   clr,
  output logic [NCH-1:0]   armed,
  output logic [NCH-1:0]   viol_pulse,
  output logic [NCH-1:0]   tmo_pulse,
  output logic [NCH-1:0]   viol_sticky,
  output logic [NCH-1:0]   tmo_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_vld,
  output logic [CH_W-1:0]  first_ch
);

  typedef enum logic {IDLE, ARMED} state_t;

  localparam int SUM_W = $clog2(2 * NCH + 1);
  localparam int W = CNT_W + SUM_W;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [GAP_W-1:0] gap_q [NCH];
  logic [GAP_W-1:0] gap_d [NCH];
  logic [NCH-1:0]   fired_q;
  logic [NCH-1:0]   fired_d;
  logic [NCH-1:0]   viol_c;
  logic [NCH-1:0]   tmo_c;
  logic [NCH-1:0]   err_c;
  logic [SUM_W-1:0] nerr;
  logic [W-1:0]     cnt_sum;
  logic [CNT_W-1:0] cnt_d;
  logic [CH_W-1:0]  low_ch;

  always_comb begin
    viol_c  = '0;
    tmo_c   = '0;
    fired_d = fired_q;
    armed   = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      gap_d[i]   = gap_q[i];
      armed[i]   = (state_q[i] == ARMED);
      if (!en) begin
        state_d[i] = IDLE;
        gap_d[i]   = '0;
        fired_d[i] = 1'b0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (sig_a[i]) begin
              state_d[i] = ARMED;
              gap_d[i]   = '0;
              fired_d[i] = 1'b0;
            end
          end
          ARMED: begin
            if (sig_a[i]) begin
              viol_c[i]  = (CLOSE_INCL != 0) && sig_b[i] && !fired_q[i];
              gap_d[i]   = '0;
              fired_d[i] = 1'b0;
            end else begin
              viol_c[i]  = sig_b[i] && !fired_q[i];
              fired_d[i] = fired_q[i] | sig_b[i];
              gap_d[i]   = gap_q[i] + 1'b1;
              // a=0 on the last legal slot closes the window as a timeout
              if ((MAX_GAP != 0) && (gap_q[i] == GAP_LAST)) begin
                tmo_c[i]   = 1'b1;
                state_d[i] = IDLE;
                gap_d[i]   = '0;
              end
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    err_c  = viol_c | tmo_c;
    nerr   = '0;
    low_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      nerr = nerr + SUM_W'(viol_c[i]) + SUM_W'(tmo_c[i]);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (err_c[i]) low_ch = CH_W'(i);
    end
    cnt_sum = W'(err_cnt) + W'(nerr);
    cnt_d   = (cnt_sum > W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        gap_q[i]   <= '0;
      end
      fired_q     <= '0;
      viol_pulse  <= '0;
      tmo_pulse   <= '0;
      viol_sticky <= '0;
      tmo_sticky  <= '0;
      err_cnt     <= '0;
      first_vld   <= 1'b0;
      first_ch    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        gap_q[i]   <= gap_d[i];
      end
      fired_q     <= fired_d;
      viol_pulse  <= viol_c;
      tmo_pulse   <= tmo_c;
      viol_sticky <= (viol_sticky & ~clr) | viol_c;
      tmo_sticky  <= (tmo_sticky & ~clr) | tmo_c;
      err_cnt     <= cnt_d;
      // a fresh error beats a simultaneous clear
      if ((|err_c) && (!first_vld || (|clr))) begin
        first_vld <= 1'b1;
        first_ch  <= low_ch;
      end else if (|clr) begin
        first_vld <= 1'b0;
        first_ch  <= '0;
      end
    end
  end

endmodule
